psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/psum_accumulator_pkg.sv | 30 +++
 rtl/psum_accumulator_if.sv | 28 ++
 rtl/psum_out_fifo.sv | 68 ++++++
 rtl/psum_accumulator.sv | 102 ++++++++++
 tb/tb_psum_accumulator.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_accumulator_pkg.sv
// Shared widths and arithmetic helpers for the partial-sum accumulator.
// Holds SUM_IN_W, the default ACC_W, and the saturating add used per term.
package psum_accumulator_pkg;

  localparam int SUM_IN_W  = 8;
  localparam int ACC_W_DEF = 10;
  localparam int MAX_ACC_W = 32;

  // Unsigned add of one tree result onto a running sum that is w bits
  // wide; clamps at 2^w-1 instead of wrapping.
  function automatic logic [MAX_ACC_W-1:0] sat_add(
    input logic [MAX_ACC_W-1:0] acc,
    input logic [SUM_IN_W-1:0]  term,
    input int unsigned          w
  );
    logic [MAX_ACC_W:0] one;
    logic [MAX_ACC_W:0] lim;
    logic [MAX_ACC_W:0] sum;
    one = {{MAX_ACC_W{1'b0}}, 1'b1};
    lim = (one << w) - one;
    sum = {1'b0, acc}
        + {{(MAX_ACC_W + 1 - SUM_IN_W){1'b0}}, term};
    if (sum > lim) begin
      sat_add = lim[MAX_ACC_W-1:0];
    end else begin
      sat_add = sum[MAX_ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Output stream of completed group sums (valid/ready handshake).
// master: drives out_valid/out_data/out_last_partial; slave: drives out_ready.
interface psum_accumulator_if
  import psum_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
);

  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_last_partial;

  modport master (
    output out_valid,
    output out_data,
    output out_last_partial,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last_partial,
    output out_ready
  );

endinterface

// File: rtl/psum_out_fifo.sv
// Small FIFO buffering completed groups ahead of the consumer.
// Ports: clk, reset, push/push_data, pop, full, empty, head (0 when empty).
module psum_out_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] inc(
    input logic [PTR_W-1:0] p
  );
    inc = (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  // A push into a full buffer still lands when the head leaves
  // in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= inc(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates NUM_TERMS adder-tree results per group and buffers sums.
// Ports: clk, reset, sum_valid/sum_in, flush, busy, overflow_err, out_stream.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int NUM_TERMS  = 4,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sum_valid,
  input  logic [SUM_IN_W-1:0] sum_in,
  input  logic                flush,
  output logic                busy,
  output logic                overflow_err,
  psum_accumulator_if.master  out_stream
);

  localparam int CNT_W = $clog2(NUM_TERMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_next;
  logic [ACC_W-1:0]     acc_d;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_d;
  logic [MAX_ACC_W-1:0] acc_sat;
  logic                 complete;
  logic                 partial;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [ACC_W:0]       head;

  assign acc_sat = sat_add(MAX_ACC_W'(acc), sum_in, ACC_W);

  // Saturation keeps the result inside ACC_W bits, so the rest is spare.
  if (ACC_W < MAX_ACC_W) begin : g_spare
    logic unused_sat;
    assign unused_sat = ^acc_sat[MAX_ACC_W-1:ACC_W];
  end

  always_comb begin
    acc_next = acc;
    if (sum_valid) begin
      acc_next = acc_sat[ACC_W-1:0];
    end
    complete = sum_valid && (cnt == LAST);
    // A flush landing on the natural last term is an ordinary completion.
    partial  = flush && !complete
            && (sum_valid || (cnt != '0));
    push     = complete || partial;
    acc_d    = acc;
    cnt_d    = cnt;
    if (push) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sum_valid) begin
      acc_d = acc_next;
      cnt_d = cnt + CNT_W'(1);
    end
  end

  assign pop = out_stream.out_valid && out_stream.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      acc  <= acc_d;
      cnt  <= cnt_d;
      busy <= (cnt_d != '0);
      if (push && full && !pop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  psum_out_fifo #(
    .WIDTH (ACC_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({partial, acc_next}),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign out_stream.out_valid        = !empty;
  assign out_stream.out_data         = head[ACC_W-1:0];
  assign out_stream.out_last_partial = head[ACC_W];

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench: two DUTs (ACC_W=10 and ACC_W=8) share stimulus.
// A group-level model predicts every output; directed literals pin the model.
module tb_psum_accumulator;
  import psum_accumulator_pkg::*;

  localparam int NT    = 4;
  localparam int DEPTH = 2;
  localparam int W0    = 10;
  localparam int W1    = 8;

  typedef struct {
    int unsigned d;
    bit          p;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sum_valid;
  logic [7:0] sum_in;
  logic       flush;
  logic       out_ready;
  logic       busy0, ovf0, busy1, ovf1;

  int checks   = 0;
  int failures = 0;

  psum_accumulator_if #(.ACC_W(W0)) b0 ();
  psum_accumulator_if #(.ACC_W(W1)) b1 ();

  assign b0.out_ready = out_ready;
  assign b1.out_ready = out_ready;

  psum_accumulator #(
    .NUM_TERMS(NT), .ACC_W(W0), .FIFO_DEPTH(DEPTH)
  ) dut0 (
    .clk(clk), .reset(reset), .sum_valid(sum_valid),
    .sum_in(sum_in), .flush(flush), .busy(busy0),
    .overflow_err(ovf0), .out_stream(b0.master)
  );

  psum_accumulator #(
    .NUM_TERMS(NT), .ACC_W(W1), .FIFO_DEPTH(DEPTH)
  ) dut1 (
    .clk(clk), .reset(reset), .sum_valid(sum_valid),
    .sum_in(sum_in), .flush(flush), .busy(busy1),
    .overflow_err(ovf1), .out_stream(b1.master)
  );

  always #5 clk = ~clk;

  int unsigned dd [2];
  bit          dv [2];
  bit          dl [2];
  bit          db [2];
  bit          dov[2];

  always_comb begin
    dd[0]  = 32'(b0.out_data);
    dd[1]  = 32'(b1.out_data);
    dv[0]  = b0.out_valid;
    dv[1]  = b1.out_valid;
    dl[0]  = b0.out_last_partial;
    dl[1]  = b1.out_last_partial;
    db[0]  = busy0;
    db[1]  = busy1;
    dov[0] = ovf0;
    dov[1] = ovf1;
  end

  task automatic chk(input string name, input int unsigned act,
                     input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: per-instance group sum, term count, buffered groups, flag.
  int unsigned m_acc[2];
  int unsigned m_cnt[2];
  int unsigned m_n  [2];
  bit          m_ovf[2];
  ent_t        mq   [2][DEPTH];
  bit          started = 1'b0;

  int unsigned maxv, nacc, ncnt;
  bit          pop, full, done, part;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      maxv = (i == 0) ? ((1 << W0) - 1) : ((1 << W1) - 1);
      if (reset) begin
        m_acc[i] = 0;
        m_cnt[i] = 0;
        m_n[i]   = 0;
        m_ovf[i] = 0;
      end else begin
        pop  = (m_n[i] > 0) && out_ready;
        full = (m_n[i] == DEPTH);
        nacc = m_acc[i] + (sum_valid ? 32'(sum_in) : 0);
        if (nacc > maxv) nacc = maxv;
        ncnt = m_cnt[i] + (sum_valid ? 1 : 0);
        done = (ncnt == NT);
        part = flush && (ncnt > 0) && !done;
        if (pop) begin
          for (int j = 0; j < DEPTH - 1; j++) mq[i][j] = mq[i][j+1];
          m_n[i]--;
        end
        if (done || part) begin
          if (full && !pop) begin
            m_ovf[i] = 1;
          end else begin
            mq[i][m_n[i]].d = nacc;
            mq[i][m_n[i]].p = part;
            m_n[i]++;
          end
          m_acc[i] = 0;
          m_cnt[i] = 0;
        end else begin
          m_acc[i] = nacc;
          m_cnt[i] = ncnt;
        end
      end
    end
    if (reset) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("valid%0d", i), 32'(dv[i]), 32'(m_n[i] > 0));
        if (m_n[i] > 0) begin
          chk($sformatf("data%0d", i), dd[i], mq[i][0].d);
          chk($sformatf("last%0d", i), 32'(dl[i]), 32'(mq[i][0].p));
        end
        chk($sformatf("busy%0d", i), 32'(db[i]), 32'(m_cnt[i] != 0));
        chk($sformatf("ovf%0d", i), 32'(dov[i]), 32'(m_ovf[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic term(input int unsigned v);
    sum_valid = 1'b1;
    sum_in    = 8'(v);
    step();
  endtask

  task automatic idle();
    sum_valid = 1'b0;
    flush     = 1'b0;
    step();
  endtask

  initial begin
    reset     = 1'b1;
    sum_valid = 1'b0;
    sum_in    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", 32'(b0.out_valid), 0);
    chk("rst_data", dd[0], 0);
    chk("rst_last", 32'(b0.out_last_partial), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_ovf", 32'(ovf0), 0);

    term(10); term(20); term(30);
    chk("g1_busy", 32'(busy0), 1);
    chk("g1_early", 32'(b0.out_valid), 0);
    term(40);
    chk("g1_valid", 32'(b0.out_valid), 1);
    chk("g1_data", dd[0], 100);
    chk("g1_last", 32'(b0.out_last_partial), 0);
    idle();
    chk("g1_popped", 32'(b0.out_valid), 0);

    for (int k = 0; k < 4; k++) term(240);
    chk("b2b_first", dd[0], 960);
    chk("b2b_first8", dd[1], 255);
    for (int k = 0; k < 4; k++) term(240);
    chk("b2b_valid", 32'(b0.out_valid), 1);
    chk("b2b_second", dd[0], 960);
    chk("b2b_ovf", 32'(ovf0), 0);
    idle();

    term(200); term(200); term(5); term(5);
    chk("sat8_data", dd[1], 255);
    chk("sat10_data", dd[0], 410);
    idle();

    term(7); term(9);
    chk("fl_busy", 32'(busy0), 1);
    sum_valid = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_data", dd[0], 16);
    chk("fl_last", 32'(b0.out_last_partial), 1);
    chk("fl_busy0", 32'(busy0), 0);
    idle();
    for (int k = 0; k < 4; k++) term(1);
    chk("fl_next", dd[0], 4);
    chk("fl_next_last", 32'(b0.out_last_partial), 0);
    idle();

    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) term(1);
    idle();
    chk("ov_flag", 32'(ovf0), 1);
    chk("ov_head", dd[0], 4);
    out_ready = 1'b1;
    step();
    chk("ov_pop1_valid", 32'(b0.out_valid), 1);
    chk("ov_pop2_data", dd[0], 4);
    step();
    chk("ov_empty", 32'(b0.out_valid), 0);
    chk("ov_sticky", 32'(ovf0), 1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r_ovf_clr", 32'(ovf0), 0);
    term(5); term(6);
    reset     = 1'b1;
    sum_valid = 1'b1;
    sum_in    = 8'd9;
    flush     = 1'b1;
    step();
    reset     = 1'b0;
    sum_valid = 1'b0;
    flush     = 1'b0;
    chk("r_busy", 32'(busy0), 0);
    chk("r_valid", 32'(b0.out_valid), 0);
    for (int k = 0; k < 4; k++) term(1);
    chk("r_data", dd[0], 4);
    chk("r_ovf", 32'(ovf0), 0);
    idle();
    idle();
    chk("r_single", 32'(b0.out_valid), 0);

    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      sum_valid = ($urandom_range(0, 3) != 0);
      sum_in    = 8'($urandom_range(0, 255));
      flush     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 1) == 0);
      step();
    end
    reset     = 1'b0;
    sum_valid = 1'b0;
    flush     = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
